dfi_mem_resp: RTL and testbench
===============================

DFI_MEM_RESP -- requirements
Module: dfi_mem_resp

Interface
REQ-001 Parameters: BA_W, default 2, bank address width (4 banks).
REQ-002 Parameters: ADDR_W, default 14, DFI address width; column index = dfi_address[3:0].
REQ-003 Parameters: DATA_W, default 64, DFI write/read data width.
REQ-004 Parameters: WL, default 3, write latency in cycles (range 1-8); RL, default 5, read latency in cycles (range 1-8).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n  input  1 each  DFI command pins.
REQ-008 dfi_bank  input  BA_W  bank address; dfi_address  input  ADDR_W  row/column address.
REQ-009 dfi_wrdata_en  input  1, dfi_wrdata  input  DATA_W  write data from the controller.
REQ-010 dfi_rddata_valid  output  1, dfi_rddata  output  DATA_W  read data returned to the controller.
REQ-011 err_o  output  1  sticky protocol-violation flag; rd_cnt_o, wr_cnt_o  output  16 each  completed-access counters.

Function
REQ-012 Decode {cs_n,ras_n,cas_n,we_n}: 0011 ACT, 0101 RD, 0100 WR, 0010 PRE, 0001 REF, 0111 NOP; cs_n=1 is deselect, any other code is NOP.
REQ-013 Per bank, a two-state FSM: CLOSED --ACT--> OPEN (row latched from dfi_address); OPEN --PRE--> CLOSED; PRE to a CLOSED bank is legal and has no effect.
REQ-014 Storage is 2^(BA_W+4) words of DATA_W, indexed {dfi_bank, dfi_address[3:0]}; the row is ignored and aliasing is permitted.
REQ-015 A RD to an OPEN bank samples storage in the command cycle; dfi_rddata_valid is high for exactly one cycle, RL cycles later, with that data on dfi_rddata.
REQ-016 dfi_rddata is 0 whenever dfi_rddata_valid is 0.
REQ-017 A WR to an OPEN bank queues its index; exactly WL cycles later dfi_wrdata_en must be 1, and dfi_wrdata is written at that edge.
REQ-018 The read pipeline (RL stages) and the write pipeline (WL stages) are shift registers that accept one command per cycle and operate concurrently; back-to-back commands every cycle are supported.
REQ-019 A RD to an index with a pending write returns the pre-write contents; no forwarding.
REQ-020 err_o is set, and stays set until rst, on any of the following:
- ACT to an OPEN bank;
- RD or WR to a CLOSED bank;
- REF while any bank is OPEN;
- dfi_wrdata_en=1 with no write due that cycle;
- dfi_wrdata_en=0 when a write is due.
REQ-021 An illegal RD produces no dfi_rddata_valid pulse; an illegal WR is dropped, with no storage update and no wrdata_en expectation.
REQ-022 rd_cnt_o increments on each dfi_rddata_valid pulse; wr_cnt_o increments on each storage write; both saturate at 0xFFFF.
REQ-023 REF with all banks CLOSED is legal and changes no state.

Reset
REQ-024 While rst=1, all of the following hold:
- all banks are CLOSED;
- both pipelines are emptied;
- storage is zeroed;
- dfi_rddata_valid=0, dfi_rddata=0, err_o=0, rd_cnt_o=0, wr_cnt_o=0.
REQ-025 Assertion of rst mid-burst discards in-flight reads and writes; after deassertion no stale valid pulse or write occurs.

Structure
REQ-026 The command encoding enum (ACT, RD, WR, PRE, REF, NOP) and the 4-bit pin codes belong in a shared DFI package, reused by the command encoder.
REQ-027 The per-bank CLOSED/OPEN FSM is one sub-module, dfi_bank_fsm, instantiated 2^BA_W times in a generate loop.

Verification
REQ-028 Sequence: ACT b1 row 0x12 -> WR b1 col 3 with wrdata 0xA5A5 at WL=3 -> RD b1 col 3 -> dfi_rddata_valid RL=5 cycles after the RD with data 0xA5A5; wr_cnt_o=1, rd_cnt_o=1, err_o=0.
REQ-029 Issue RD to b2 without an ACT -> no dfi_rddata_valid pulse, err_o=1 on the next cycle.
REQ-030 Issue four RDs on consecutive cycles to b0 cols 0-3 -> four consecutive valid pulses starting RL cycles after the first RD, in issue order.
REQ-031 Issue WR b0 col 5, but hold dfi_wrdata_en=0 at WL -> err_o=1 and storage[b0,5] remains 0.
REQ-032 Issue RD, then assert rst two cycles later for one cycle -> no dfi_rddata_valid pulse ever appears; counters=0.
REQ-033 Issue ACT b0, then REF -> err_o=1; then PRE b0 and REF after a fresh reset -> err_o stays 0.

Source files
------------

// File: rtl/dfi_mem_resp_pkg.sv
// Shared DFI command definitions: pin codes, decoded command enum and helpers.
// Bank state encoding is shared between the bank FSM and anything observing it.
package dfi_mem_resp_pkg;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_RD,
        CMD_WR,
        CMD_PRE,
        CMD_REF
    } dfi_cmd_e;

    typedef enum logic {
        BANK_CLOSED,
        BANK_OPEN
    } bank_state_e;

    // Pin order is {cs_n, ras_n, cas_n, we_n}.
    localparam logic [3:0] PIN_ACT = 4'b0011;
    localparam logic [3:0] PIN_RD  = 4'b0101;
    localparam logic [3:0] PIN_WR  = 4'b0100;
    localparam logic [3:0] PIN_PRE = 4'b0010;
    localparam logic [3:0] PIN_REF = 4'b0001;
    localparam logic [3:0] PIN_NOP = 4'b0111;

    function automatic dfi_cmd_e dfi_decode(input logic [3:0] pins);
        dfi_cmd_e cmd;
        cmd = CMD_NOP;
        case (pins)
            PIN_ACT: cmd = CMD_ACT;
            PIN_RD:  cmd = CMD_RD;
            PIN_WR:  cmd = CMD_WR;
            PIN_PRE: cmd = CMD_PRE;
            PIN_REF: cmd = CMD_REF;
            default: cmd = CMD_NOP;
        endcase
        return cmd;
    endfunction

    function automatic logic [3:0] dfi_encode(input dfi_cmd_e cmd);
        logic [3:0] pins;
        pins = PIN_NOP;
        case (cmd)
            CMD_ACT: pins = PIN_ACT;
            CMD_RD:  pins = PIN_RD;
            CMD_WR:  pins = PIN_WR;
            CMD_PRE: pins = PIN_PRE;
            CMD_REF: pins = PIN_REF;
            default: pins = PIN_NOP;
        endcase
        return pins;
    endfunction

endpackage

// File: rtl/dfi_bank_fsm.sv
// One bank's CLOSED/OPEN state plus its latched row address.
// An ACT to an already open bank is ignored here; the top flags it as an error.
module dfi_bank_fsm
    import dfi_mem_resp_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              act_i,
    input  logic              pre_i,
    input  logic [ADDR_W-1:0] row_i,
    output logic              open_o
);

    bank_state_e       state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BANK_CLOSED;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        case (state_q)
            BANK_CLOSED: begin
                if (act_i) begin
                    state_d = BANK_OPEN;
                    row_d   = row_i;
                end
            end
            BANK_OPEN: begin
                if (pre_i) begin
                    state_d = BANK_CLOSED;
                    row_d   = '0;
                end
            end
            default: state_d = BANK_CLOSED;
        endcase
    end

    assign open_o = (state_q == BANK_OPEN);

    // The row is only meaningful while open; it is cleared on precharge.
    always_comb begin
        if (!rst) begin
            assert (state_q == BANK_OPEN || row_q == '0);
        end
    end

endmodule

// File: rtl/dfi_mem_resp.sv
// DFI memory responder: per-bank open tracking, fixed-latency read and write
// pipelines over a small column-indexed store, and protocol error detection.
module dfi_mem_resp
    import dfi_mem_resp_pkg::*;
#(
    parameter int BA_W   = 2,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 64,
    parameter int WL     = 3,
    parameter int RL     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dfi_cs_n,
    input  logic              dfi_ras_n,
    input  logic              dfi_cas_n,
    input  logic              dfi_we_n,
    input  logic [BA_W-1:0]   dfi_bank,
    input  logic [ADDR_W-1:0] dfi_address,
    input  logic              dfi_wrdata_en,
    input  logic [DATA_W-1:0] dfi_wrdata,
    output logic              dfi_rddata_valid,
    output logic [DATA_W-1:0] dfi_rddata,
    output logic              err_o,
    output logic [15:0]       rd_cnt_o,
    output logic [15:0]       wr_cnt_o
);

    localparam int NB    = 1 << BA_W;
    localparam int IDX_W = BA_W + 4;
    localparam int DEPTH = 1 << IDX_W;

    dfi_cmd_e          cmd;
    logic [NB-1:0]     bankOpen, actSel, preSel;
    logic              selOpen, rdOk, wrOk, wrDue, wrFire;
    logic [IDX_W-1:0]  cmdIdx;
    logic              err_q, err_d;
    logic [15:0]       rdCnt_q, rdCnt_d, wrCnt_q, wrCnt_d;
    logic [DATA_W-1:0] mem_q     [DEPTH];
    logic              rdVld_q   [RL];
    logic [DATA_W-1:0] rdData_q  [RL];
    logic              wrVld_q   [WL];
    logic [IDX_W-1:0]  wrIdx_q   [WL];

    assign cmd     = dfi_decode({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n});
    assign selOpen = bankOpen[dfi_bank];
    assign cmdIdx  = {dfi_bank, dfi_address[3:0]};
    assign rdOk    = (cmd == CMD_RD) && selOpen;
    assign wrOk    = (cmd == CMD_WR) && selOpen;
    assign wrDue   = wrVld_q[WL-1];
    assign wrFire  = wrDue && dfi_wrdata_en;

    always_comb begin
        actSel = '0;
        preSel = '0;
        if (cmd == CMD_ACT) actSel[dfi_bank] = 1'b1;
        if (cmd == CMD_PRE) preSel[dfi_bank] = 1'b1;
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        dfi_bank_fsm #(.ADDR_W(ADDR_W)) u_fsm (
            .clk    (clk),
            .rst    (rst),
            .act_i  (actSel[b]),
            .pre_i  (preSel[b]),
            .row_i  (dfi_address),
            .open_o (bankOpen[b])
        );
    end

    always_comb begin
        err_d = err_q
              | ((cmd == CMD_ACT) && selOpen)
              | (((cmd == CMD_RD) || (cmd == CMD_WR)) && !selOpen)
              | ((cmd == CMD_REF) && (|bankOpen))
              | (dfi_wrdata_en != wrDue);
        rdCnt_d = rdCnt_q;
        wrCnt_d = wrCnt_q;
        if (dfi_rddata_valid && (rdCnt_q != 16'hFFFF)) rdCnt_d = rdCnt_q + 16'd1;
        if (wrFire && (wrCnt_q != 16'hFFFF))           wrCnt_d = wrCnt_q + 16'd1;
    end

    // Reads sample storage in the command cycle, so a same-edge write is not seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RL; i++) begin
                rdVld_q[i]  <= 1'b0;
                rdData_q[i] <= '0;
            end
            for (int i = 0; i < WL; i++) begin
                wrVld_q[i] <= 1'b0;
                wrIdx_q[i] <= '0;
            end
            err_q   <= 1'b0;
            rdCnt_q <= '0;
            wrCnt_q <= '0;
        end else begin
            rdVld_q[0]  <= rdOk;
            rdData_q[0] <= rdOk ? mem_q[cmdIdx] : '0;
            for (int i = 1; i < RL; i++) begin
                rdVld_q[i]  <= rdVld_q[i-1];
                rdData_q[i] <= rdData_q[i-1];
            end
            wrVld_q[0] <= wrOk;
            wrIdx_q[0] <= wrOk ? cmdIdx : '0;
            for (int i = 1; i < WL; i++) begin
                wrVld_q[i] <= wrVld_q[i-1];
                wrIdx_q[i] <= wrIdx_q[i-1];
            end
            err_q   <= err_d;
            rdCnt_q <= rdCnt_d;
            wrCnt_q <= wrCnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wrFire) begin
            mem_q[wrIdx_q[WL-1]] <= dfi_wrdata;
        end
    end

    assign dfi_rddata_valid = rdVld_q[RL-1];
    assign dfi_rddata       = rdVld_q[RL-1] ? rdData_q[RL-1] : '0;
    assign err_o            = err_q;
    assign rd_cnt_o         = rdCnt_q;
    assign wr_cnt_o         = wrCnt_q;

endmodule

// File: tb/tb_dfi_mem_resp.sv
// Testbench for dfi_mem_resp: directed scenarios plus randomized legal traffic
// checked against a cycle-keyed schedule model of reads, writes and bank state.
module tb_dfi_mem_resp;

    localparam int WL = 3;
    localparam int RL = 5;

    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] DES = 4'b1111;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  pins;
    logic [1:0]  bank;
    logic [13:0] address;
    logic        wrdataEn;
    logic [63:0] wrdata;
    logic        rddataValid;
    logic [63:0] rddata;
    logic        err;
    logic [15:0] rdCnt, wrCnt;

    int nVec  = 0;
    int nFail = 0;

    // Reference model: bank state, storage, and expected events keyed by cycle.
    int          cyc = 0;
    bit          mOpen [4];
    logic [63:0] mMem  [64];
    bit          mErr;
    int          mRd, mWr;
    bit          rvSched [int];
    logic [63:0] rdSched [int];
    int          wrSched [int];
    bit          mValid;
    logic [63:0] mData;

    dfi_mem_resp #(.BA_W(2), .ADDR_W(14), .DATA_W(64), .WL(WL), .RL(RL)) dut (
        .clk              (clk),
        .rst              (rst),
        .dfi_cs_n         (pins[3]),
        .dfi_ras_n        (pins[2]),
        .dfi_cas_n        (pins[1]),
        .dfi_we_n         (pins[0]),
        .dfi_bank         (bank),
        .dfi_address      (address),
        .dfi_wrdata_en    (wrdataEn),
        .dfi_wrdata       (wrdata),
        .dfi_rddata_valid (rddataValid),
        .dfi_rddata       (rddata),
        .err_o            (err),
        .rd_cnt_o         (rdCnt),
        .wr_cnt_o         (wrCnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Drives one cycle of stimulus and advances the model; outputs are then sampled 1ns after the edge.
    task automatic tick(input logic r, input logic [3:0] p, input int ba, input int addr,
                        input logic wen, input logic [63:0] wd);
        int idx;
        bit due;
        bit anyOpen;
        @(negedge clk);
        rst      = r;
        pins     = p;
        bank     = ba[1:0];
        address  = addr[13:0];
        wrdataEn = wen;
        wrdata   = wd;
        if (r) begin
            foreach (mOpen[i]) mOpen[i] = 1'b0;
            foreach (mMem[i]) mMem[i] = '0;
            mErr = 1'b0;
            mRd  = 0;
            mWr  = 0;
            rvSched.delete();
            rdSched.delete();
            wrSched.delete();
        end else begin
            idx     = (ba % 4) * 16 + (addr % 16);
            due     = wrSched.exists(cyc);
            anyOpen = mOpen[0] | mOpen[1] | mOpen[2] | mOpen[3];
            if (rvSched.exists(cyc) && mRd < 65535) mRd++;
            if (wen != due) mErr = 1'b1;
            case (p)
                ACT: if (mOpen[ba]) mErr = 1'b1; else mOpen[ba] = 1'b1;
                RD: begin
                    if (mOpen[ba]) begin
                        rvSched[cyc + RL] = 1'b1;
                        rdSched[cyc + RL] = mMem[idx];
                    end else mErr = 1'b1;
                end
                WR:  if (mOpen[ba]) wrSched[cyc + WL] = idx; else mErr = 1'b1;
                PRE: mOpen[ba] = 1'b0;
                REF: if (anyOpen) mErr = 1'b1;
                default: ;
            endcase
            if (due && wen) begin
                mMem[wrSched[cyc]] = wd;
                if (mWr < 65535) mWr++;
            end
            if (rvSched.exists(cyc)) begin
                rvSched.delete(cyc);
                rdSched.delete(cyc);
            end
            if (due) wrSched.delete(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        mValid = rvSched.exists(cyc);
        mData  = mValid ? rdSched[cyc] : 64'h0;
    endtask

    task automatic nop();
        tick(1'b0, NOP, 0, 0, 1'b0, 64'h0);
    endtask

    task automatic doReset();
        tick(1'b1, NOP, 0, 0, 1'b0, 64'h0);
        tick(1'b1, NOP, 0, 0, 1'b0, 64'h0);
    endtask

    task automatic test_reset();
        doReset();
        nVec++; if (rddataValid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid: got %b expected 0", rddataValid); end
        nVec++; if (rddata !== 64'h0) begin nFail++; $display("[TB] FAIL reset_rddata: got %h expected 0", rddata); end
        nVec++; if (err !== 1'b0) begin nFail++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        nVec++; if (rdCnt !== 16'h0) begin nFail++; $display("[TB] FAIL reset_rdcnt: got %0d expected 0", rdCnt); end
        nVec++; if (wrCnt !== 16'h0) begin nFail++; $display("[TB] FAIL reset_wrcnt: got %0d expected 0", wrCnt); end
        nop();
    endtask

    task automatic test_write_read();
        bit early;
        doReset();
        tick(1'b0, ACT, 1, 14'h12, 1'b0, 64'h0);
        tick(1'b0, WR, 1, 3, 1'b0, 64'h0);
        repeat (WL - 1) nop();
        tick(1'b0, NOP, 0, 0, 1'b1, 64'hA5A5);
        nVec++; if (wrCnt !== 16'd1) begin nFail++; $display("[TB] FAIL wr_cnt: got %0d expected 1", wrCnt); end
        tick(1'b0, RD, 1, 3, 1'b0, 64'h0);
        early = 1'b0;
        repeat (RL - 1) begin
            if (rddataValid !== 1'b0) early = 1'b1;
            nop();
        end
        nVec++; if (early) begin nFail++; $display("[TB] FAIL rd_early: got early pulse expected none before RL"); end
        nVec++; if (rddataValid !== 1'b1) begin nFail++; $display("[TB] FAIL rd_valid: got %b expected 1", rddataValid); end
        nVec++; if (rddata !== 64'hA5A5) begin nFail++; $display("[TB] FAIL rd_data: got %h expected a5a5", rddata); end
        nop();
        nVec++; if (rddataValid !== 1'b0) begin nFail++; $display("[TB] FAIL rd_single: got %b expected 0", rddataValid); end
        nVec++; if (rdCnt !== 16'd1) begin nFail++; $display("[TB] FAIL rd_cnt: got %0d expected 1", rdCnt); end
        nVec++; if (err !== 1'b0) begin nFail++; $display("[TB] FAIL wr_rd_err: got %b expected 0", err); end
    endtask

    task automatic test_illegal_read();
        bit seen;
        doReset();
        tick(1'b0, RD, 2, 7, 1'b0, 64'h0);
        nVec++; if (err !== 1'b1) begin nFail++; $display("[TB] FAIL illegal_rd_err: got %b expected 1", err); end
        seen = 1'b0;
        repeat (RL + 2) begin
            if (rddataValid !== 1'b0) seen = 1'b1;
            nop();
        end
        nVec++; if (seen) begin nFail++; $display("[TB] FAIL illegal_rd_pulse: got pulse expected none"); end
        nVec++; if (rdCnt !== 16'd0) begin nFail++; $display("[TB] FAIL illegal_rd_cnt: got %0d expected 0", rdCnt); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d [4];
        int          k;
        logic        wen;
        logic [63:0] wd;
        doReset();
        for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
        tick(1'b0, ACT, 0, 0, 1'b0, 64'h0);
        for (int j = 0; j < 4 + WL; j++) begin
            wen = (j >= WL) && (j < WL + 4);
            wd  = 64'h0;
            if (wen) wd = d[j - WL];
            tick(1'b0, (j < 4) ? WR : NOP, 0, (j < 4) ? j : 0, wen, wd);
        end
        nVec++; if (wrCnt !== 16'd4) begin nFail++; $display("[TB] FAIL b2b_wr_cnt: got %0d expected 4", wrCnt); end
        for (int j = 0; j < 4 + RL; j++) begin
            tick(1'b0, (j < 4) ? RD : NOP, 0, (j < 4) ? j : 0, 1'b0, 64'h0);
            k = j + 1 - RL;
            nVec++;
            if (rddataValid !== ((k >= 0) && (k < 4))) begin
                nFail++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected %b", j, rddataValid, (k >= 0) && (k < 4));
            end
            if (k >= 0 && k < 4) begin
                nVec++;
                if (rddata !== d[k]) begin nFail++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", k, rddata, d[k]); end
            end
        end
        nVec++; if (rdCnt !== 16'd4) begin nFail++; $display("[TB] FAIL b2b_rd_cnt: got %0d expected 4", rdCnt); end
        nVec++; if (err !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_err: got %b expected 0", err); end
    endtask

    task automatic test_missing_wrdata();
        doReset();
        tick(1'b0, ACT, 0, 0, 1'b0, 64'h0);
        tick(1'b0, WR, 0, 5, 1'b0, 64'h0);
        repeat (WL - 1) nop();
        nVec++; if (err !== 1'b0) begin nFail++; $display("[TB] FAIL miss_pre_err: got %b expected 0", err); end
        tick(1'b0, NOP, 0, 0, 1'b0, 64'hDEAD);
        nVec++; if (err !== 1'b1) begin nFail++; $display("[TB] FAIL miss_err: got %b expected 1", err); end
        nVec++; if (wrCnt !== 16'd0) begin nFail++; $display("[TB] FAIL miss_wr_cnt: got %0d expected 0", wrCnt); end
        tick(1'b0, RD, 0, 5, 1'b0, 64'h0);
        repeat (RL - 1) nop();
        nVec++; if (rddataValid !== 1'b1) begin nFail++; $display("[TB] FAIL miss_rd_valid: got %b expected 1", rddataValid); end
        nVec++; if (rddata !== 64'h0) begin nFail++; $display("[TB] FAIL miss_storage: got %h expected 0", rddata); end
    endtask

    task automatic test_reset_midburst();
        bit seen;
        doReset();
        tick(1'b0, ACT, 0, 0, 1'b0, 64'h0);
        tick(1'b0, RD, 0, 1, 1'b0, 64'h0);
        tick(1'b0, WR, 0, 2, 1'b0, 64'h0);
        tick(1'b1, NOP, 0, 0, 1'b0, 64'h0);
        seen = 1'b0;
        repeat (2 * RL) begin
            if (rddataValid !== 1'b0) seen = 1'b1;
            nop();
        end
        nVec++; if (seen) begin nFail++; $display("[TB] FAIL midrst_pulse: got stale pulse expected none"); end
        nVec++; if (rdCnt !== 16'd0) begin nFail++; $display("[TB] FAIL midrst_rd_cnt: got %0d expected 0", rdCnt); end
        nVec++; if (wrCnt !== 16'd0) begin nFail++; $display("[TB] FAIL midrst_wr_cnt: got %0d expected 0", wrCnt); end
        nVec++; if (err !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_err: got %b expected 0", err); end
    endtask

    task automatic test_refresh();
        doReset();
        tick(1'b0, ACT, 0, 0, 1'b0, 64'h0);
        tick(1'b0, REF, 0, 0, 1'b0, 64'h0);
        nVec++; if (err !== 1'b1) begin nFail++; $display("[TB] FAIL ref_open_err: got %b expected 1", err); end
        doReset();
        tick(1'b0, ACT, 0, 0, 1'b0, 64'h0);
        tick(1'b0, PRE, 0, 0, 1'b0, 64'h0);
        tick(1'b0, PRE, 3, 0, 1'b0, 64'h0);
        tick(1'b0, REF, 0, 0, 1'b0, 64'h0);
        tick(1'b0, DES, 0, 0, 1'b0, 64'h0);
        nVec++; if (err !== 1'b0) begin nFail++; $display("[TB] FAIL ref_closed_err: got %b expected 0", err); end
        tick(1'b0, ACT, 2, 0, 1'b0, 64'h0);
        tick(1'b0, ACT, 2, 0, 1'b0, 64'h0);
        nVec++; if (err !== 1'b1) begin nFail++; $display("[TB] FAIL act_open_err: got %b expected 1", err); end
    endtask

    task automatic test_random();
        int          op, ba, addr;
        logic [3:0]  p;
        logic        wen;
        bit          anyOpen;
        doReset();
        for (int n = 0; n < 400; n++) begin
            op      = $urandom_range(0, 9);
            ba      = $urandom_range(0, 3);
            addr    = $urandom_range(0, 16383);
            anyOpen = mOpen[0] | mOpen[1] | mOpen[2] | mOpen[3];
            case (op)
                0:       p = mOpen[ba] ? PRE : ACT;
                1, 2, 3: p = mOpen[ba] ? RD : ACT;
                4, 5, 6: p = mOpen[ba] ? WR : ACT;
                7:       p = anyOpen ? PRE : REF;
                8:       p = DES;
                default: p = NOP;
            endcase
            wen = wrSched.exists(cyc);
            if (n > 350 && $urandom_range(0, 40) == 0) wen = ~wen;
            tick(1'b0, p, ba, addr, wen, {$urandom, $urandom});
            nVec++; if (rddataValid !== mValid) begin nFail++; $display("[TB] FAIL rnd_valid@%0d: got %b expected %b", cyc, rddataValid, mValid); end
            nVec++; if (rddata !== mData) begin nFail++; $display("[TB] FAIL rnd_data@%0d: got %h expected %h", cyc, rddata, mData); end
            nVec++; if (err !== mErr) begin nFail++; $display("[TB] FAIL rnd_err@%0d: got %b expected %b", cyc, err, mErr); end
            nVec++; if (rdCnt !== mRd[15:0]) begin nFail++; $display("[TB] FAIL rnd_rd_cnt@%0d: got %0d expected %0d", cyc, rdCnt, mRd); end
            nVec++; if (wrCnt !== mWr[15:0]) begin nFail++; $display("[TB] FAIL rnd_wr_cnt@%0d: got %0d expected %0d", cyc, wrCnt, mWr); end
        end
    endtask

    initial begin
        rst      = 1'b1;
        pins     = NOP;
        bank     = '0;
        address  = '0;
        wrdataEn = 1'b0;
        wrdata   = '0;
        test_reset();
        test_write_read();
        test_illegal_read();
        test_back_to_back();
        test_missing_wrdata();
        test_reset_midburst();
        test_refresh();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
